// File: rtl/wbuart_pkg.sv
`default_nettype none
//==============================================================================
// Module : wbuart_pkg
// Desc   : Shared types and constants for the wbuart family.
// Rev    : 1.0  initial release
//==============================================================================
package wbuart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // Bit positions of the sticky error flags, shared with the status word
    localparam int c_ERR_OVR = 0;
    localparam int c_ERR_PAR = 1;
    localparam int c_ERR_FRM = 2;

endpackage
`default_nettype wire

// File: rtl/wbuart_sync_fifo.sv
`default_nettype none
//==============================================================================
// Module : wbuart_sync_fifo
// Desc   : Single-clock first-word-fall-through FIFO with occupancy outputs.
// Rev    : 1.0  initial release
//==============================================================================
module wbuart_sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int LGFIFO = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_rd,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [LGFIFO:0]   o_fill,
    output logic [LGFIFO:0]   o_fill_nxt
);
    localparam int             c_DEPTH = 1 << LGFIFO;
    localparam int             c_FW    = LGFIFO + 1;
    localparam logic [LGFIFO:0] c_FULL = c_FW'(c_DEPTH);

    logic [WIDTH-1:0]  r_mem [c_DEPTH];
    logic [LGFIFO-1:0] r_wptr;
    logic [LGFIFO-1:0] r_rptr;
    logic [LGFIFO:0]   r_fill;
    logic              w_rd_ok;
    logic              w_wr_ok;

    assign o_empty    = (r_fill == '0);
    assign o_full     = (r_fill == c_FULL);
    // A pop frees the slot in the same edge, so a full FIFO still accepts
    assign w_rd_ok    = i_rd & ~o_empty;
    assign w_wr_ok    = i_wr & (~o_full | w_rd_ok);
    assign o_fill_nxt = r_fill + c_FW'(w_wr_ok) - c_FW'(w_rd_ok);
    assign o_fill     = r_fill;
    assign o_data     = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
            r_fill <= o_fill_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wbuart_rxchan.sv
`default_nettype none
//==============================================================================
// Module : wbuart_rxchan
// Desc   : Oversampled UART receiver with configurable frame format, FWFT
//          RX FIFO, sticky error flags and RTS flow control.
// Rev    : 1.0  initial release
//==============================================================================
module wbuart_rxchan
    import wbuart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 25,
    parameter int DATA_BITS       = 8,
    parameter int PARITY_EN       = 0,
    parameter int PARITY_ODD      = 0,
    parameter int LGFIFO          = 4,
    parameter int RTS_MARGIN      = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_uart_rx,
    output logic [7:0]        o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_overrun,
    output logic              o_parity_err,
    output logic              o_frame_err,
    input  logic              i_clear_err,
    output logic              o_rts_n
);
    localparam int              c_CW       = $clog2(CLOCKS_PER_BAUD + 1);
    localparam int              c_FW       = LGFIFO + 1;
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(CLOCKS_PER_BAUD);
    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(CLOCKS_PER_BAUD / 2);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [3:0]      c_LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [LGFIFO:0] c_RTS_LVL  = c_FW'((1 << LGFIFO) - RTS_MARGIN);

    rx_state_t              r_state, w_state_nxt;
    logic [1:0]             r_sync;
    logic [c_CW-1:0]        r_cnt;
    logic [3:0]             r_bitcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bad;
    logic [2:0]             r_err;
    logic                   r_rts_n;

    logic                   w_rx_s;
    logic                   w_expire;
    logic                   w_load_half, w_load_full, w_shift, w_par_smp;
    logic                   w_push, w_par_set, w_frm_set, w_ovf;
    logic                   w_pop;
    logic [2:0]             w_err_set;
    logic                   w_empty, w_full;
    logic [DATA_BITS-1:0]   w_head;
    logic [LGFIFO:0]        w_fill_nxt;

    assign w_rx_s   = r_sync[1];
    assign w_expire = (r_cnt == c_CNT_ONE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_uart_rx};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift     = 1'b0;
        w_par_smp   = 1'b0;
        w_push      = 1'b0;
        w_par_set   = 1'b0;
        w_frm_set   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) begin
                    w_load_half = 1'b1;
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (w_expire) begin
                    if (w_rx_s) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_load_full = 1'b1;
                        w_state_nxt = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (w_expire) begin
                    w_shift     = 1'b1;
                    w_load_full = 1'b1;
                    if (r_bitcnt == c_LAST_BIT) begin
                        w_state_nxt = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (w_expire) begin
                    w_par_smp   = 1'b1;
                    w_load_full = 1'b1;
                    w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_expire) begin
                    if (w_rx_s) begin
                        w_push      = ~r_par_bad;
                        w_par_set   = r_par_bad;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_frm_set   = 1'b1;
                        w_state_nxt = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (w_rx_s) w_state_nxt = RX_IDLE;
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_load_half)      r_cnt <= c_CNT_HALF;
            else if (w_load_full) r_cnt <= c_CNT_FULL;
            else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;

            if (w_load_half) begin
                r_bitcnt  <= '0;
                r_par_bad <= 1'b0;
            end
            if (w_shift) begin
                r_bitcnt <= r_bitcnt + 1'b1;
                r_shift  <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
            if (w_par_smp) begin
                r_par_bad <= (w_rx_s != ((^r_shift) ^ (PARITY_ODD != 0)));
            end
        end
    end

    assign w_pop = i_ready & ~w_empty;
    assign w_ovf = w_push & w_full & ~w_pop;

    always_comb begin
        w_err_set            = '0;
        w_err_set[c_ERR_OVR] = w_ovf;
        w_err_set[c_ERR_PAR] = w_par_set;
        w_err_set[c_ERR_FRM] = w_frm_set;
    end

    // Set takes priority over a simultaneous clear
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_err   <= '0;
            r_rts_n <= 1'b0;
        end else begin
            r_err   <= (i_clear_err ? 3'b000 : r_err) | w_err_set;
            r_rts_n <= (w_fill_nxt >= c_RTS_LVL);
        end
    end

    wbuart_sync_fifo #(
        .WIDTH  (DATA_BITS),
        .LGFIFO (LGFIFO)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_wr       (w_push),
        .i_data     (r_shift),
        .i_rd       (i_ready),
        .o_data     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_fill     (o_fill),
        .o_fill_nxt (w_fill_nxt)
    );

    assign o_valid      = ~w_empty;
    assign o_data       = o_valid ? 8'(w_head) : 8'h00;
    assign o_overrun    = r_err[c_ERR_OVR];
    assign o_parity_err = r_err[c_ERR_PAR];
    assign o_frame_err  = r_err[c_ERR_FRM];
    assign o_rts_n      = r_rts_n;

endmodule
`default_nettype wire

// File: tb/tb_wbuart_rxchan.sv
`default_nettype none
//==============================================================================
// Module : tb_wbuart_rxchan
// Desc   : Self-checking bench for wbuart_rxchan across four frame/FIFO setups.
// Rev    : 1.0  initial release
//==============================================================================
module tb_wbuart_rxchan;
    localparam int CPB = 25;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rx, rdy, clr;
    logic [7:0] dat [4];
    logic [3:0] val, ovr, perr, ferr, rts;
    logic [4:0] fl0, fl1, fl3;
    logic [2:0] fl2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       exp_push;
        logic [7:0] exp_d;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    always #5 clk = ~clk;

    // u0: 8N1 depth 16; u1: 8O1 depth 16; u2: 8N1 depth 4; u3: 5E1 depth 16
    wbuart_rxchan #(.CLOCKS_PER_BAUD(CPB)) u0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx[0]), .o_data(dat[0]),
        .o_valid(val[0]), .i_ready(rdy[0]), .o_fill(fl0), .o_overrun(ovr[0]),
        .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .i_clear_err(clr[0]),
        .o_rts_n(rts[0]));
    wbuart_rxchan #(.CLOCKS_PER_BAUD(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx[1]), .o_data(dat[1]),
        .o_valid(val[1]), .i_ready(rdy[1]), .o_fill(fl1), .o_overrun(ovr[1]),
        .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .i_clear_err(clr[1]),
        .o_rts_n(rts[1]));
    wbuart_rxchan #(.CLOCKS_PER_BAUD(CPB), .LGFIFO(2), .RTS_MARGIN(1)) u2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx[2]), .o_data(dat[2]),
        .o_valid(val[2]), .i_ready(rdy[2]), .o_fill(fl2), .o_overrun(ovr[2]),
        .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .i_clear_err(clr[2]),
        .o_rts_n(rts[2]));
    wbuart_rxchan #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(5), .PARITY_EN(1)) u3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx[3]), .o_data(dat[3]),
        .o_valid(val[3]), .i_ready(rdy[3]), .o_fill(fl3), .o_overrun(ovr[3]),
        .o_parity_err(perr[3]), .o_frame_err(ferr[3]), .i_clear_err(clr[3]),
        .o_rts_n(rts[3]));

    function automatic int get_fill(input int idx);
        case (idx)
            0:       return int'(fl0);
            1:       return int'(fl1);
            2:       return int'(fl2);
            default: return int'(fl3);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic put_bit(input int idx, input logic b);
        rx[idx] = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [7:0] d, input int nbits,
                              input bit par_en, input bit par_bit, input bit stop_bit);
        @(posedge clk); #1;
        put_bit(idx, 1'b0);
        for (int i = 0; i < nbits; i++) put_bit(idx, d[i]);
        if (par_en) put_bit(idx, par_bit);
        put_bit(idx, stop_bit);
        rx[idx] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop(input int idx);
        @(posedge clk); #1;
        rdy[idx] = 1'b1;
        @(posedge clk); #1;
        rdy[idx] = 1'b0;
    endtask

    task automatic pulse_clr(input int idx);
        @(posedge clk); #1;
        clr[idx] = 1'b1;
        @(posedge clk); #1;
        clr[idx] = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.u%0d.valid", tag, k), 32'(val[k]), 0);
            chk($sformatf("%s.u%0d.data", tag, k), 32'(dat[k]), 0);
            chk($sformatf("%s.u%0d.fill", tag, k), get_fill(k), 0);
            chk($sformatf("%s.u%0d.flags", tag, k), {29'd0, ferr[k], perr[k], ovr[k]}, 0);
            chk($sformatf("%s.u%0d.rts_n", tag, k), 32'(rts[k]), 0);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [6];
        int         lat;
        logic [7:0] q [$];
        bit         m_ovr, m_par, m_frm;
        logic [7:0] d;
        bit         bad_par, bad_stop, pbit;

        // 5 data bits, even parity: parity bit = XOR of the data bits
        tbl[0] = '{8'h1F, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{8'h15, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h0A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{8'h13, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
        tbl[5] = '{8'h0C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        rx    = 4'hF;
        rdy   = 4'h0;
        clr   = 4'h0;
        idle(3);
        check_reset("reset");
        rst_n = 1'b1;
        idle(5);

        // Pin-to-valid latency for 8N1 at 25 clocks/bit
        lat = -1;
        fork
            send_frame(0, 8'h1E, 8, 0, 0, 1);
            begin
                @(posedge clk); #1;
                for (int n = 1; n <= 300; n++) begin
                    @(posedge clk); #1;
                    if (val[0] && lat < 0) lat = n;
                end
            end
        join
        chk("latency", lat, 240);
        chk("8n1.data", dat[0], 8'h1E);
        chk("8n1.fill", get_fill(0), 1);
        chk("8n1.flags", {ferr[0], perr[0], ovr[0]}, 0);
        pop(0);
        chk("8n1.fill_after_pop", get_fill(0), 0);

        // Odd parity on 0xA5 (four ones) requires parity bit 1
        send_frame(1, 8'hA5, 8, 1, 1, 1);
        idle(3);
        chk("par.good.data", dat[1], 8'hA5);
        chk("par.good.perr", perr[1], 0);
        pop(1);
        send_frame(1, 8'hA5, 8, 1, 0, 1);
        idle(3);
        chk("par.bad.fill", get_fill(1), 0);
        chk("par.bad.perr", perr[1], 1);
        pulse_clr(1);
        chk("par.clear", perr[1], 0);

        // Short glitch is a false start
        @(posedge clk); #1;
        rx[0] = 1'b0;
        idle(5);
        rx[0] = 1'b1;
        idle(60);
        chk("glitch.fill", get_fill(0), 0);
        chk("glitch.flags", {ferr[0], perr[0], ovr[0]}, 0);

        // Line held low for 20 bit times: one frame error only
        rx[0] = 1'b0;
        idle(260);
        chk("break.ferr", ferr[0], 1);
        pulse_clr(0);
        idle(238);
        chk("break.no_second_ferr", ferr[0], 0);
        rx[0] = 1'b1;
        idle(30);
        chk("break.fill", get_fill(0), 0);
        chk("break.flags", {ferr[0], perr[0], ovr[0]}, 0);
        send_frame(0, 8'h5A, 8, 0, 0, 1);
        idle(3);
        chk("break.recover.data", dat[0], 8'h5A);
        pop(0);

        // 5-bit even-parity format vectors
        for (int i = 0; i < 6; i++) begin
            send_frame(3, tbl[i].d, 5, 1, tbl[i].par, tbl[i].stop);
            idle(5);
            chk($sformatf("tbl%0d.valid", i), val[3], tbl[i].exp_push);
            chk($sformatf("tbl%0d.fill", i), get_fill(3), 32'(tbl[i].exp_push));
            chk($sformatf("tbl%0d.data", i), dat[3], tbl[i].exp_d);
            chk($sformatf("tbl%0d.perr", i), perr[3], tbl[i].exp_perr);
            chk($sformatf("tbl%0d.ferr", i), ferr[3], tbl[i].exp_ferr);
            if (tbl[i].exp_push) pop(3);
            pulse_clr(3);
        end

        // Overflow on a depth-4 FIFO with RTS margin 1
        for (int i = 0; i < 5; i++) begin
            send_frame(2, 8'(8'h11 * (i + 1)), 8, 0, 0, 1);
            idle(2);
            if (i == 1) chk("ovf.rts_after2", rts[2], 0);
            if (i == 2) chk("ovf.rts_after3", rts[2], 1);
            if (i == 3) chk("ovf.ovr_after4", ovr[2], 0);
        end
        chk("ovf.fill", get_fill(2), 4);
        chk("ovf.ovr", ovr[2], 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf.order%0d", i), dat[2], 8'(8'h11 * (i + 1)));
            pop(2);
        end
        chk("ovf.drained", get_fill(2), 0);
        chk("ovf.rts_drained", rts[2], 0);
        pulse_clr(2);

        for (int i = 0; i < 4; i++) send_frame(2, 8'(8'h61 + i), 8, 0, 0, 1);
        fork
            send_frame(2, 8'h65, 8, 0, 0, 1);
            begin
                @(posedge clk); #1;
                repeat (239) @(posedge clk);
                #1;
                rdy[2] = 1'b1;
                @(posedge clk); #1;
                rdy[2] = 1'b0;
            end
        join
        idle(2);
        chk("popovf.ovr", ovr[2], 0);
        chk("popovf.fill", get_fill(2), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("popovf.order%0d", i), dat[2], 8'(8'h62 + i));
            pop(2);
        end

        // Randomised odd-parity frames against a queue model
        m_ovr = 0; m_par = 0; m_frm = 0;
        for (int i = 0; i < 24; i++) begin
            d        = 8'($urandom_range(0, 255));
            bad_par  = ($urandom_range(0, 3) == 0);
            bad_stop = ($urandom_range(0, 4) == 0);
            pbit     = (^d) ^ 1'b1 ^ bad_par;
            send_frame(1, d, 8, 1, pbit, !bad_stop);
            idle(5);
            if (bad_stop)          m_frm = 1;
            else if (bad_par)      m_par = 1;
            else if (q.size() == 16) m_ovr = 1;
            else                   q.push_back(d);
            chk($sformatf("rnd%0d.fill", i), get_fill(1), q.size());
            chk($sformatf("rnd%0d.valid", i), val[1], q.size() != 0);
            chk($sformatf("rnd%0d.flags", i), {ferr[1], perr[1], ovr[1]}, {m_frm, m_par, m_ovr});
            chk($sformatf("rnd%0d.rts", i), rts[1], q.size() >= 14);
            if (q.size() != 0) chk($sformatf("rnd%0d.head", i), dat[1], q[0]);
            if (q.size() != 0 && $urandom_range(0, 2) == 0) begin
                pop(1);
                void'(q.pop_front());
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr(1);
                m_ovr = 0; m_par = 0; m_frm = 0;
            end
        end
        while (q.size() != 0) begin
            chk("rnd.drain", dat[1], q[0]);
            pop(1);
            void'(q.pop_front());
        end
        chk("rnd.empty", get_fill(1), 0);

        // Reset in the middle of a frame, with data left in u2
        send_frame(2, 8'h77, 8, 0, 0, 1);
        @(posedge clk); #1;
        rx[0] = 1'b0;
        idle(100);
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        rx[0] = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(60);
        chk("midreset.fill", get_fill(0), 0);
        chk("midreset.flags", {ferr[0], perr[0], ovr[0]}, 0);
        send_frame(0, 8'hC3, 8, 0, 0, 1);
        idle(3);
        chk("midreset.next.data", dat[0], 8'hC3);
        chk("midreset.next.fill", get_fill(0), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
